dsm_bit_pacer: RTL
==================

# dsm_bit_pacer

Synthesizable multi-channel delta-sigma bitstream source that replaces file-driven bench stimulus for the decimation chain. It accepts packed bitstream words over a valid/ready interface, buffers them in a small FIFO, and emits one bit per channel on `dsm_in`, strobing `dsm_en` once every `div_cfg+1` clocks. It sits directly upstream of `dsm_decimation_chain` (one chain per channel). It generalises the fixed 1-channel, fixed-rate pacing to parametrised channel count, word width, FIFO depth and a runtime rate divider, and adds underrun detection.

## Interface
- `NUM_CH`, default 2: number of parallel DSM channels.
- `WORD_W`, default 32: bits per channel per input word.
- `FIFO_DEPTH`, default 8: input word FIFO depth; must be a power of 2, ≥2.
- `DIV_W`, default 16: width of the rate divider.

Ports:
- `clk`  in  1  system clock (100 MHz nominal).
- `rst`  in  1  reset; single clock domain, synchronous, active-high.
- `enable`  in  1  run/stop pacing.
- `div_cfg`  in  DIV_W  clocks per sample minus 1; 1220 gives 81.92 kHz at 100 MHz.
- `s_data`  in  NUM_CH*WORD_W  channel c in `[c*WORD_W +: WORD_W]`, LSB sent first.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  FIFO not full.
- `dsm_in`  out  NUM_CH  current bit per channel (registered).
- `dsm_en`  out  1  one-cycle sample strobe.
- `underrun`  out  1  sticky: a sample tick found no data.
- `underrun_clr`  in  1  clears `underrun`.
- `sample_cnt`  out  32  samples emitted, wraps at 2^32.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- Push on `s_valid && s_ready`; `s_ready = !full`, so no push while full, even if a pop occurs in the same cycle.
- Output bits are taken directly from the FIFO head at `bit_idx`; no separate shift register. After the bit at `bit_idx == WORD_W-1` is emitted, the word is popped and `bit_idx` returns to 0.
- FSM states:
  - IDLE: counter held at 0. Go to RUN when `enable` and FIFO non-empty.
  - RUN: counter counts 0..`div_cfg`. At the tick (`count == div_cfg`), emit a bit and reset the counter. If the tick pops the last word, go to STARVED.
  - STARVED: counter keeps running. On a tick with FIFO empty, set `underrun` and emit nothing; `dsm_in` holds. When the FIFO becomes non-empty, go to RUN; the next tick emits.
  - From any state, `enable` low goes to IDLE, zeroes the counter, and retains `bit_idx` and the FIFO contents.
- `div_cfg` is compared live; 0 means a tick every cycle. A change takes effect at the next compare. If the new value is below the current count, the counter runs to wrap, then ticks at the new value.
- `underrun` set and `underrun_clr` in the same cycle: set wins.
- `sample_cnt` increments on every emitted sample.

## Timing
- Reset (`rst` high at an edge):
  - `dsm_in`=0, `dsm_en`=0, `underrun`=0, `sample_cnt`=0, `busy`=0.
  - `s_ready`=0 while `rst` is high and 1 in the first cycle after.
  - FIFO flushed, `bit_idx`=0, FSM in IDLE.
- Reset mid-word discards all buffered data.
- IDLE→RUN transition at edge E: the first `dsm_en` is high in the cycle after edge E+`div_cfg`+1. Subsequent strobes are spaced exactly `div_cfg`+1 cycles apart while data is present.
- `dsm_in` updates on the same edge that raises `dsm_en` and is stable until the next strobe.
- Push-to-first-strobe latency with an empty FIFO and `enable` high: `div_cfg`+2 cycles.
- FIFO occupancy updates one cycle after a push; `s_ready` drops in the cycle after the push that fills the FIFO.

## Structure
- Package `dsm_pkg` holds:
  - `DSM_CLK_FREQ_HZ` = 100_000_000, `DSM_RATE_HZ` = 81920, `DSM_CLKS_PER_SAMPLE` = 1221.
  - The FSM state enum `dsm_pacer_state_t` {IDLE, RUN, STARVED}.
- One sub-module, `dsm_word_fifo`: a register-array FIFO with a combinational head read, and full/empty from pointers with an extra wrap bit.

## Test plan
- NUM_CH=1, WORD_W=8, div_cfg=3; push 8'hA5 with `enable` high:
  - `dsm_en` strobes every 4 cycles, `dsm_in` = 1,0,1,0,0,1,0,1.
  - `sample_cnt`=8, FSM enters STARVED, `underrun`=1 at the 9th tick.
- `enable`=0, FIFO_DEPTH=8, push 9 words back-to-back: 8 accepted, `s_ready`=0, the 9th is held. Raise `enable` → `s_ready` returns after the first pop (WORD_W ticks later).
- div_cfg=1220, 200 samples: every `dsm_en` interval is exactly 1221 cycles; `sample_cnt`=200.
- NUM_CH=2, word {ch1=8'h00, ch0=8'hFF}: `dsm_in`=2'b01 on all 8 strobes.
- Reset asserted after 3 bits of a word:
  - All outputs are 0 and `busy`=0.
  - A new pushed word 8'h01 emits 1 first (`bit_idx` restarted at 0).
- Drain FIFO, then pulse `underrun_clr` in the same cycle as a starved tick → `underrun` stays 1. A later lone `underrun_clr` → 0.

Source files
------------

// File: rtl/dsm_pkg.sv
// Shared constants and FSM state type for the delta-sigma bitstream pacer.
package dsm_pkg;

    localparam int DSM_CLK_FREQ_HZ     = 100_000_000;
    localparam int DSM_RATE_HZ         = 81920;
    localparam int DSM_CLKS_PER_SAMPLE = 1221;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STARVED = 2'd2
    } dsm_pacer_state_t;

endpackage

// File: rtl/dsm_word_fifo.sv
// Register-array word FIFO; head is read combinationally, full/empty come
// from read/write pointers carrying one extra wrap bit.
module dsm_word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/dsm_bit_pacer.sv
// Multi-channel delta-sigma bitstream source: buffers packed words and emits
// one bit per channel every div_cfg+1 clocks, flagging underruns.
//
// state   | meaning
// IDLE    | stopped, counter held at 0, bit_idx and FIFO retained
// RUN     | pacing; each tick emits the head bit of every channel
// STARVED | last word consumed; ticks with an empty FIFO set underrun
module dsm_bit_pacer
    import dsm_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         div_cfg,
    input  logic [NUM_CH*WORD_W-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [NUM_CH-1:0]        dsm_in,
    output logic                     dsm_en,
    output logic                     underrun,
    input  logic                     underrun_clr,
    output logic [31:0]              sample_cnt,
    output logic                     busy
);

    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    dsm_pacer_state_t state, state_nxt;

    logic [DIV_W-1:0]         count;
    logic [BW-1:0]            bit_idx;
    logic [NUM_CH*WORD_W-1:0] head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [LW-1:0]            fifo_level;
    logic                     push;
    logic                     tick;
    logic                     emit;
    logic                     word_done;
    logic                     starve_tick;
    logic                     last_pop;
    logic [NUM_CH-1:0]        cur_bits;
    logic [WORD_W-1:0]        ch_word;

    // s_ready is forced low during reset so nothing is accepted into a FIFO being flushed.
    assign s_ready = !fifo_full && !rst;
    assign push    = s_valid && s_ready;
    assign busy    = (state != IDLE) || !fifo_empty;

    dsm_word_fifo #(
        .WIDTH (NUM_CH*WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (s_data),
        .pop     (word_done),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (!fifo_empty) state_nxt = RUN;
                RUN:     if (last_pop)    state_nxt = STARVED;
                STARVED: if (!fifo_empty) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        tick        = (state != IDLE) && enable && (count == div_cfg);
        emit        = tick && (state == RUN) && !fifo_empty;
        word_done   = emit && (bit_idx == BW'(WORD_W-1));
        starve_tick = tick && (state == STARVED) && fifo_empty;
        // A push landing in the same cycle keeps the FIFO non-empty, so stay in RUN.
        last_pop    = word_done && (fifo_level == LW'(1)) && !push;
    end

    always_comb begin
        cur_bits = '0;
        ch_word  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_word     = head[c*WORD_W +: WORD_W];
            cur_bits[c] = ch_word[bit_idx];
        end
    end

    // Equality compare against the live divider: a value lowered below the
    // current count lets the counter run through wrap before the next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if ((state == IDLE) || (state_nxt == IDLE) || tick) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dsm_in     <= '0;
            dsm_en     <= 1'b0;
            underrun   <= 1'b0;
            sample_cnt <= '0;
            bit_idx    <= '0;
        end else begin
            dsm_en <= emit;
            if (emit) begin
                dsm_in     <= cur_bits;
                sample_cnt <= sample_cnt + 32'd1;
                bit_idx    <= word_done ? '0 : bit_idx + BW'(1);
            end
            if (starve_tick)       underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
        end
    end

endmodule
